wb_vram_arbiter: RTL
====================

# wb_vram_arbiter

Two-master Wishbone arbiter that shares the single VRAM slave port between the VGA display fetch master and the CPU data master. Master 0 (display refill) has priority so scan-out does not underrun. A fairness counter guarantees the CPU (master 1) a grant after a bounded number of display grants. A per-transaction watchdog terminates hung cycles with an error pulse so a dead slave cannot freeze the display.

## Interface
- MAX_M0_GRANTS, 4: consecutive m0 grants allowed while m1 is waiting before m1 is forced through (1..15).
- TIMEOUT, 255: cycles with stb high and no ack before the watchdog fires (1..255, 8-bit counter).

- clk  in  1  bus clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_cyc_i  in  1  master 0 bus-cycle request.
- m0_stb_i  in  1  master 0 strobe.
- m0_addr_i  in  [31:2]  master 0 word address.
- m0_cti_i  in  3  master 0 cycle type.
- m0_bte_i  in  2  master 0 burst type.
- m0_sel_i  in  4  master 0 byte selects.
- m0_we_i  in  1  master 0 write enable.
- m0_data_i  in  32  master 0 write data.
- m0_data_o  out  32  read data; s_data_i broadcast unconditionally.
- m0_ack_o  out  1  s_ack_i gated by grant to m0.
- m0_err_o  out  1  watchdog error pulse to m0.
- m1_* (same eleven signals as m0_*)  in/out  same widths  master 1, CPU.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to VRAM slave.
- s_addr_o  out  [31:2]  to VRAM slave.
- s_cti_o  out  3  to VRAM slave.
- s_bte_o  out  2  to VRAM slave.
- s_sel_o  out  4  to VRAM slave.
- s_data_o  out  32  to VRAM slave.
- s_data_i  in  32  from VRAM slave.
- s_ack_i  in  1  from VRAM slave.
- gnt_o  out  2  one-hot current owner; 2'b00 when idle.

## Operation
- States: IDLE, GNT0, GNT1. Registered state; the slave-side mux and ack/err routing are combinational from the state.
- In IDLE, s_cyc_o and s_stb_o are 0 and all other s_* outputs are 0.
- In GNTx, all s_* outputs equal mx_* inputs.
- Ack routing: mx_ack_o = s_ack_i & (state==GNTx). The non-owner never sees ack.
- IDLE transitions, evaluated on m0_cyc_i/m1_cyc_i only (stb not required):
  - m0 requesting and (m1 not requesting or starve_cnt < MAX_M0_GRANTS) -> GNT0.
  - Otherwise, m1 requesting -> GNT1.
  - Neither requesting -> stay in IDLE.
- starve_cnt (4-bit) update rule:
  - increments on each IDLE->GNT0 taken while m1_cyc_i=1;
  - clears on IDLE->GNT1, and on any cycle with m1_cyc_i=0;
  - saturates at 15.
- GNTx -> IDLE when mx_cyc_i=0. The grant is held across bursts and multi-beat cycles until cyc drops; cti/bte are passed through, never interpreted.
- Watchdog (8-bit wd_cnt):
  - clears in IDLE and on every cycle with s_ack_i=1;
  - increments in GNTx while mx_stb_i=1 and s_ack_i=0.
- When wd_cnt==TIMEOUT:
  - mx_err_o=1 for exactly that cycle;
  - s_cyc_o/s_stb_o are forced to 0 that cycle;
  - the next state is IDLE regardless of mx_cyc_i.
- After a watchdog abort, a master still holding cyc re-arbitrates normally.

## Timing
- Reset (async, immediate): state=IDLE, starve_cnt=0, wd_cnt=0. Consequently s_cyc_o=s_stb_o=0, all s_* outputs 0, m*_ack_o=m*_err_o=0, gnt_o=0. mx_data_o still follows s_data_i.
- Reset asserted mid-transaction drops s_cyc_o in the same cycle; no ack is delivered after reset.
- Arbitration latency: cyc seen high at edge N -> grant from N+1; s_cyc_o is visible during the cycle after edge N.
- Ack and read data pass through with zero added latency.
- Ownership change: at least one IDLE cycle (s_cyc_o=0) between any two grants, including back-to-back requests from the same master.
- A simultaneous m0/m1 request in IDLE is resolved by the priority/starvation rule; any request arriving while in GNTx waits without being latched.
- Error pulse width is 1 cycle; err and ack are never high in the same cycle to the same master.

## Test plan
- Reset mid-burst:
  - Stimulus: m0 in an 8-beat burst, rst pulsed for 3 cycles at beat 4.
  - Required: s_cyc_o=0 and gnt_o=0 within the reset cycle; no m0_ack_o after reset; normal grant the cycle after m0 re-requests.
- Single read:
  - Stimulus: m1 alone reads address 0x100, slave acks in 2 cycles with 0xCAFEF00D.
  - Required: gnt_o=2'b10 one cycle after cyc; m1_ack_o with data 0xCAFEF00D; m0_ack_o stays 0.
- Contention and fairness:
  - Stimulus: m0 and m1 requesting continuously, each cycle 1 beat, MAX_M0_GRANTS=4.
  - Required: grant order 0,0,0,0,1,0,0,0,0,1,…; each grant separated by exactly 1 IDLE cycle.
- Burst hold:
  - Stimulus: m0 issues an 8-beat incrementing burst (cti=3'b010, last beat 3'b111) while m1 requests.
  - Required: m1 is not granted until after m0 drops cyc; all 8 acks route to m0 only.
- Watchdog:
  - Stimulus: TIMEOUT=16, m1 strobes and the slave never acks.
  - Required: m1_err_o pulses exactly once, 16 cycles after stb; s_cyc_o=0 that cycle; state returns to IDLE; m0 pending request granted next.

Source files
------------

// File: rtl/wb_vram_arbiter.sv
// wb_vram_arbiter: two-master Wishbone arbiter for the shared VRAM slave.
// Master 0 (display refill) has priority. A starvation counter forces the
// CPU (master 1) through after MAX_M0_GRANTS display grants. A watchdog
// aborts hung cycles with a one-cycle error pulse.
//
// Ports:
//   clk, rst             bus clock, async active-high reset
//   m0_* / m1_*          Wishbone master ports (cyc, stb, addr, cti, bte,
//                        sel, we, data in; data, ack, err out)
//   s_*                  Wishbone port towards the VRAM slave
//   gnt_o                one-hot current owner, 2'b00 when idle
module wb_vram_arbiter #(
    parameter int MAX_M0_GRANTS = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:2] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:2] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:2] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAXG = 4'(MAX_M0_GRANTS);
    localparam logic [7:0] LP_TO   = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    logic [7:0] r_wd;
    logic [7:0] w_wd_nxt;
    logic       w_timeout;
    logic       w_own_stb;

    // Counter is only nonzero while granted, so no state qualifier needed
    // beyond excluding IDLE.
    assign w_timeout = (r_state != IDLE) && (r_wd == LP_TO);

    assign w_own_stb = ((r_state == GNT0) && m0_stb_i) ||
                       ((r_state == GNT1) && m1_stb_i);

    // Read data is broadcast; only ack qualifies it.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_starve <= 4'd0;
            r_wd     <= 8'd0;
        end else begin
            r_state  <= w_next;
            r_starve <= w_starve_nxt;
            r_wd     <= w_wd_nxt;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_starve_nxt = r_starve;
        w_wd_nxt     = r_wd;

        unique case (r_state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || (r_starve < LP_MAXG)))
                    w_next = GNT0;
                else if (m1_cyc_i)
                    w_next = GNT1;
            end
            GNT0: begin
                if (w_timeout || !m0_cyc_i)
                    w_next = IDLE;
            end
            GNT1: begin
                if (w_timeout || !m1_cyc_i)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        // Starvation counts only display grants that jumped a waiting CPU.
        if (!m1_cyc_i)
            w_starve_nxt = 4'd0;
        else if (r_state == IDLE && w_next == GNT1)
            w_starve_nxt = 4'd0;
        else if (r_state == IDLE && w_next == GNT0 && r_starve != 4'hF)
            w_starve_nxt = r_starve + 4'd1;

        if (r_state == IDLE || s_ack_i || w_timeout)
            w_wd_nxt = 8'd0;
        else if (w_own_stb)
            w_wd_nxt = r_wd + 8'd1;
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_cti_o  = 3'd0;
        s_bte_o  = 2'd0;
        s_sel_o  = 4'd0;
        s_data_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;

        unique case (r_state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i && !w_timeout;
                s_stb_o  = m0_stb_i && !w_timeout;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                s_sel_o  = m0_sel_i;
                s_data_o = m0_data_i;
                // A late ack on the abort cycle is dropped so err and ack
                // never coincide.
                m0_ack_o = s_ack_i && !w_timeout;
                m0_err_o = w_timeout;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i && !w_timeout;
                s_stb_o  = m1_stb_i && !w_timeout;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                s_sel_o  = m1_sel_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i && !w_timeout;
                m1_err_o = w_timeout;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
